// File: rtl/dma_burst_splitter_if.sv
// Command-in / burst-out bundle for dma_burst_splitter.
// slave is the splitter's view, master is the command source / axi_dma side.
interface dma_burst_splitter_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int LEN_WIDTH  = 24
);
  logic                  cmd_valid_i;
  logic                  cmd_ready_o;
  logic [ADDR_WIDTH-1:0] cmd_addr_i;
  logic [LEN_WIDTH-1:0]  cmd_len_i;
  logic                  burst_valid_o;
  logic                  burst_ready_i;
  logic [ADDR_WIDTH-1:0] burst_addr_o;
  logic [7:0]            burst_len_o;
  logic                  burst_last_o;
  logic                  busy_o;
  logic                  err_o;

  modport slave (
    input  cmd_valid_i,
    output cmd_ready_o,
    input  cmd_addr_i,
    input  cmd_len_i,
    output burst_valid_o,
    input  burst_ready_i,
    output burst_addr_o,
    output burst_len_o,
    output burst_last_o,
    output busy_o,
    output err_o
  );

  modport master (
    output cmd_valid_i,
    input  cmd_ready_o,
    output cmd_addr_i,
    output cmd_len_i,
    input  burst_valid_o,
    output burst_ready_i,
    input  burst_addr_o,
    input  burst_len_o,
    input  burst_last_o,
    input  busy_o,
    input  err_o
  );
endinterface

// File: rtl/dma_burst_splitter.sv
// Splits a linear (addr, len) transfer into AXI INCR bursts
// of at most MAX_BEATS beats that never cross a 4 KiB page.
module dma_burst_splitter #(
  parameter int ADDR_WIDTH = 32,
  parameter int LEN_WIDTH  = 24,
  parameter int DATA_BYTES = 8,
  parameter int MAX_BEATS  = 256
) (
  input logic clk_i,
  input logic arst_ni,
  dma_burst_splitter_if.slave bus
);

  localparam int OFFS   = $clog2(DATA_BYTES);
  localparam int REM_W  = LEN_WIDTH - OFFS + 1;
  localparam int PAGE_W = 13 - OFFS;
  localparam int CW     = (REM_W > 13) ? REM_W : 13;

  typedef enum logic {
    IDLE,
    SPLIT
  } state_e;

  state_e                state;
  logic [ADDR_WIDTH-1:0] cur_addr;
  logic [REM_W-1:0]      rem_beats;
  logic                  err_q;

  logic                  legal;
  logic [12:0]           page_bytes;
  logic [PAGE_W-1:0]     page_beats;
  logic [CW-1:0]         rem_x;
  logic [CW-1:0]         page_x;
  logic [CW-1:0]         max_x;
  logic                  sel_rem;
  logic                  sel_page;
  logic                  sel_max;
  logic [8:0]            beats;
  logic                  last;
  logic                  fire;

  assign legal =
    (bus.cmd_len_i != '0) &&
    ((bus.cmd_addr_i & ADDR_WIDTH'(DATA_BYTES - 1)) == '0) &&
    ((bus.cmd_len_i & LEN_WIDTH'(DATA_BYTES - 1)) == '0);

  // Beats left before the next 4 KiB page; 4096 when page-aligned.
  assign page_bytes = 13'd4096 - {1'b0, cur_addr[11:0]};
  assign page_beats = page_bytes[12:OFFS];

  assign rem_x  = CW'(rem_beats);
  assign page_x = CW'(page_beats);
  assign max_x  = CW'(MAX_BEATS);

  assign sel_rem  = (rem_x <= max_x) && (rem_x <= page_x);
  assign sel_page = !sel_rem && (page_x <= max_x);
  assign sel_max  = !sel_rem && !sel_page;

  always_comb begin
    beats = 9'(MAX_BEATS);
    unique case (1'b1)
      sel_rem:  beats = rem_x[8:0];
      sel_page: beats = page_x[8:0];
      sel_max:  beats = 9'(MAX_BEATS);
      default:  beats = 9'(MAX_BEATS);
    endcase
  end

  assign last = (REM_W'(beats) == rem_beats);
  assign fire = (state == SPLIT) && bus.burst_ready_i;

  always_ff @(posedge clk_i or negedge arst_ni) begin
    if (!arst_ni) begin
      state     <= IDLE;
      cur_addr  <= '0;
      rem_beats <= '0;
      err_q     <= 1'b0;
    end else begin
      err_q <= 1'b0;
      unique case (state)
        IDLE: begin
          if (bus.cmd_valid_i) begin
            if (legal) begin
              cur_addr  <= bus.cmd_addr_i;
              rem_beats <= REM_W'(bus.cmd_len_i >> OFFS);
              state     <= SPLIT;
            end else begin
              err_q <= 1'b1;
            end
          end
        end
        SPLIT: begin
          if (fire) begin
            cur_addr  <= cur_addr +
                         (ADDR_WIDTH'(beats) << OFFS);
            rem_beats <= rem_beats - REM_W'(beats);
            if (last) state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.cmd_ready_o   = (state == IDLE);
  assign bus.busy_o        = (state == SPLIT);
  assign bus.burst_valid_o = (state == SPLIT);
  assign bus.burst_addr_o  = (state == SPLIT) ? cur_addr : '0;
  assign bus.burst_len_o   = (state == SPLIT) ? 8'(beats - 9'd1) : '0;
  assign bus.burst_last_o  = (state == SPLIT) && last;
  assign bus.err_o         = err_q;

endmodule

// File: tb/tb_dma_burst_splitter.sv
// Directed bench for dma_burst_splitter (DATA_BYTES=8, MAX_BEATS=256).
// Inputs change and outputs are sampled on the falling clock edge.
module tb_dma_burst_splitter;

  logic clk_i   = 1'b0;
  logic arst_ni = 1'b0;

  int checks = 0;
  int errors = 0;

  dma_burst_splitter_if #(
    .ADDR_WIDTH(32),
    .LEN_WIDTH (24)
  ) bus ();

  dma_burst_splitter #(
    .ADDR_WIDTH(32),
    .LEN_WIDTH (24),
    .DATA_BYTES(8),
    .MAX_BEATS (256)
  ) dut (
    .clk_i  (clk_i),
    .arst_ni(arst_ni),
    .bus    (bus)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(
    input string       tag,
    input logic [63:0] got,
    input logic [63:0] exp
  );
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got 0x%0h want 0x%0h", tag, got, exp);
    end
  endtask

  task automatic idle_chk(input string tag);
    chk({tag, ".valid"}, 64'(bus.burst_valid_o), 64'd0);
    chk({tag, ".busy"},  64'(bus.busy_o),        64'd0);
    chk({tag, ".ready"}, 64'(bus.cmd_ready_o),   64'd1);
  endtask

  // Present a command for one cycle; returns on the next falling edge.
  task automatic issue(
    input logic [31:0] addr,
    input logic [23:0] len
  );
    @(negedge clk_i);
    bus.cmd_valid_i = 1'b1;
    bus.cmd_addr_i  = addr;
    bus.cmd_len_i   = len;
    @(negedge clk_i);
    bus.cmd_valid_i = 1'b0;
  endtask

  // Check the burst on offer now, then let one (ready-high) cycle pass.
  task automatic exp_burst(
    input string       tag,
    input logic [31:0] addr,
    input logic [7:0]  len,
    input logic        last
  );
    chk({tag, ".valid"}, 64'(bus.burst_valid_o), 64'd1);
    chk({tag, ".busy"},  64'(bus.busy_o),        64'd1);
    chk({tag, ".addr"},  64'(bus.burst_addr_o),  64'(addr));
    chk({tag, ".len"},   64'(bus.burst_len_o),   64'(len));
    chk({tag, ".last"},  64'(bus.burst_last_o),  64'(last));
    @(negedge clk_i);
  endtask

  task automatic bad_cmd(
    input string       tag,
    input logic [31:0] addr,
    input logic [23:0] len
  );
    issue(addr, len);
    chk({tag, ".err"}, 64'(bus.err_o), 64'd1);
    idle_chk(tag);
    @(negedge clk_i);
    chk({tag, ".err_off"}, 64'(bus.err_o), 64'd0);
    idle_chk({tag, "_2"});
  endtask

  initial begin
    bus.cmd_valid_i   = 1'b0;
    bus.cmd_addr_i    = '0;
    bus.cmd_len_i     = '0;
    bus.burst_ready_i = 1'b1;

    #12;
    idle_chk("rst");
    chk("rst.err",  64'(bus.err_o),        64'd0);
    chk("rst.addr", 64'(bus.burst_addr_o), 64'd0);
    chk("rst.len",  64'(bus.burst_len_o),  64'd0);
    @(negedge clk_i);
    arst_ni = 1'b1;

    // single burst, 1-cycle latency, ready returns after handshake
    issue(32'h1000, 24'd64);
    exp_burst("t1", 32'h1000, 8'd7, 1'b1);
    idle_chk("t1.done");

    // page crossing
    issue(32'h0FF0, 24'd64);
    exp_burst("t2a", 32'h0FF0, 8'd1, 1'b0);
    exp_burst("t2b", 32'h1000, 8'd5, 1'b1);
    idle_chk("t2.done");

    // MAX_BEATS split, back-to-back bursts
    issue(32'h0000, 24'd4096);
    exp_burst("t3a", 32'h0000, 8'd255, 1'b0);
    exp_burst("t3b", 32'h0800, 8'd255, 1'b1);
    idle_chk("t3.done");

    // stall: outputs hold, new command not taken
    bus.burst_ready_i = 1'b0;
    issue(32'h2000, 24'd32);
    bus.cmd_valid_i = 1'b1;
    bus.cmd_addr_i  = 32'h5000;
    bus.cmd_len_i   = 24'd8;
    for (int i = 0; i < 5; i++) begin
      chk("t4.valid", 64'(bus.burst_valid_o), 64'd1);
      chk("t4.addr",  64'(bus.burst_addr_o),  64'h2000);
      chk("t4.len",   64'(bus.burst_len_o),   64'd3);
      chk("t4.last",  64'(bus.burst_last_o),  64'd1);
      chk("t4.cmdrdy", 64'(bus.cmd_ready_o),  64'd0);
      @(negedge clk_i);
    end
    bus.cmd_valid_i   = 1'b0;
    bus.burst_ready_i = 1'b1;
    exp_burst("t4", 32'h2000, 8'd3, 1'b1);
    idle_chk("t4.done");
    @(negedge clk_i);
    idle_chk("t4.nopend");

    // illegal commands
    bad_cmd("t5len0",  32'h1000, 24'd0);
    bad_cmd("t5addr",  32'h1004, 24'd16);
    bad_cmd("t5len12", 32'h1000, 24'd12);

    // asynchronous reset mid-command
    issue(32'h0000, 24'd8192);
    exp_burst("t6a", 32'h0000, 8'd255, 1'b0);
    chk("t6.second", 64'(bus.burst_addr_o), 64'h0800);
    #2 arst_ni = 1'b0;
    #1;
    idle_chk("t6.async");
    @(negedge clk_i);
    arst_ni = 1'b1;
    @(negedge clk_i);
    idle_chk("t6.rel");
    @(negedge clk_i);
    idle_chk("t6.rel2");
    issue(32'h3000, 24'd8);
    exp_burst("t6b", 32'h3000, 8'd0, 1'b1);
    idle_chk("t6.done");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/dma_burst_splitter.md
Name: dma_burst_splitter

Overview:
- Command front-end directly upstream of axi_dma.
- Accepts one linear transfer command (start address, byte length) and emits a sequence of AXI-legal INCR burst commands.
- Each burst is at most MAX_BEATS beats and never crosses a 4 KiB boundary.
- axi_dma consumes one burst command per AR/AW issue; this block owns all splitting arithmetic.

Parameters:
- ADDR_WIDTH, 32, byte-address width of cmd_addr_i and burst_addr_o.
- LEN_WIDTH, 24, byte-length width of cmd_len_i.
- DATA_BYTES, 8, bus width in bytes; power of two, 1..128.
- MAX_BEATS, 256, maximum beats per burst; power of two, 1..256.

Ports:
- clk_i  in  1  clock.
- arst_ni  in  1  asynchronous active-low reset.
- cmd_valid_i  in  1  transfer command valid.
- cmd_ready_o  out  1  command accepted when high together with cmd_valid_i.
- cmd_addr_i  in  ADDR_WIDTH  start byte address.
- cmd_len_i  in  LEN_WIDTH  transfer length in bytes.
- burst_valid_o  out  1  burst command valid.
- burst_ready_i  in  1  downstream (axi_dma) accepts burst.
- burst_addr_o  out  ADDR_WIDTH  burst start address.
- burst_len_o  out  8  AxLEN encoding (beats-1).
- burst_last_o  out  1  final burst of the current command.
- busy_o  out  1  command in progress.
- err_o  out  1  one-cycle pulse: illegal command dropped.

Behaviour:
- Reset: all outputs 0 except cmd_ready_o=1. State IDLE; internal addr/remaining cleared. Reset is asynchronous and takes effect immediately, including mid-command; an in-flight command is discarded with no further bursts.
- States: IDLE, SPLIT.
- IDLE:
  - cmd_ready_o=1, burst_valid_o=0, busy_o=0.
  - On cmd_valid_i, check legality: cmd_len_i!=0, cmd_addr_i aligned to DATA_BYTES, cmd_len_i a multiple of DATA_BYTES.
  - Illegal command: err_o=1 for exactly the next cycle; stay IDLE; no burst is emitted.
  - Legal command: latch cur_addr=cmd_addr_i and rem_beats=cmd_len_i/DATA_BYTES; go to SPLIT.
- SPLIT:
  - cmd_ready_o=0, busy_o=1, burst_valid_o=1.
  - First burst_valid_o appears the cycle after command acceptance (1-cycle latency).
  - Burst size: page_beats=(4096 - cur_addr[11:0])/DATA_BYTES; beats=min(rem_beats, MAX_BEATS, page_beats).
  - burst_addr_o=cur_addr; burst_len_o=beats-1; burst_last_o=(beats==rem_beats).
  - All burst outputs are driven from registers (or purely combinational from registered state) and stay stable while burst_valid_o=1 and burst_ready_i=0.
  - On handshake: cur_addr += beats*DATA_BYTES, modulo 2^ADDR_WIDTH (wrap permitted; the 4 KiB rule splits at the top of the address space); rem_beats -= beats.
  - If burst_last_o was set on the handshake, return to IDLE. cmd_ready_o rises the following cycle; there is no back-to-back command overlap.
- burst_ready_i may be high before burst_valid_o; it has no effect outside SPLIT.
- cmd_valid_i is ignored in SPLIT; the command stays pending upstream.
- Arithmetic:
  - rem_beats width = LEN_WIDTH - log2(DATA_BYTES) + 1.
  - page_beats width covers up to 4096/DATA_BYTES.
  - The min() result always fits in 9 bits; burst_len_o is its low 8 bits minus one.
- Throughput: one burst per cycle when burst_ready_i is held high.
- err_o and busy_o are never high simultaneously.

Test Plan:
- DATA_BYTES=8, MAX_BEATS=256, cmd addr 0x1000 len 64 -> single burst addr 0x1000 len 7 last=1 on the cycle after acceptance; cmd_ready_o high again one cycle after the handshake.
- cmd addr 0x0FF0 len 64 -> burst 0x0FF0 len 1 last=0, then burst 0x1000 len 5 last=1.
- cmd addr 0x0000 len 4096 -> burst 0x0000 len 255 last=0, then 0x0800 len 255 last=1; with burst_ready_i tied high, the two bursts occur on consecutive cycles.
- cmd addr 0x2000 len 32, burst_ready_i low for 5 cycles -> burst_valid_o, addr 0x2000, len 3, last 1 held stable all 5 cycles; a new cmd_valid_i during the stall is not accepted.
- Illegal commands: len 0; addr 0x1004 len 16; addr 0x1000 len 12 -> err_o single-cycle pulse each, no burst_valid_o, busy_o stays 0, cmd_ready_o stays 1.
- Reset mid-command: cmd addr 0x0 len 8192, assert arst_ni low after the first burst handshake -> burst_valid_o/busy_o drop to 0 asynchronously. After release, cmd_ready_o=1 and no residual bursts appear. A fresh cmd addr 0x3000 len 8 yields only 0x3000 len 0 last=1.
